fwd_sel_stage: RTL and testbench
================================

# fwd_sel_stage

Parametrised N-way operand-select pipeline stage for the pipelined MIPS datapath. It generalises the 3-input forwarding multiplexer to NUM_IN sources of WIDTH bits and registers the selected operand. The stage supports stall (hold), flush (bubble insertion), valid tracking, and out-of-range select detection with a sticky flag and a saturating error counter. It sits at the ID/EX boundary, between the hazard/forwarding unit that drives `in_sel` and the ALU operand inputs.

## Interface
- `WIDTH`, 32, data width of each source and of the output.
- `NUM_IN`, 4, number of sources; legal range is 2 to 2**SEL_W.
- `SEL_W`, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- `RESET_VAL`, 0, value loaded into `out_data` on reset and on flush.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  NUM_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- `in_sel`  in  SEL_W  binary source index.
- `in_valid`  in  1  the current input carries a real instruction operand.
- `stall`  in  1  hold all stage state.
- `flush`  in  1  replace the stage contents with a bubble.
- `err_clr`  in  1  clear `sel_err` and `err_cnt`.
- `out_data`  out  WIDTH  registered selected operand.
- `out_valid`  out  1  registered valid.
- `out_sel`  out  SEL_W  registered select actually applied (0 when out-of-range was substituted).
- `sel_err`  out  1  sticky: an out-of-range select was captured with `in_valid`=1.
- `err_cnt`  out  8  saturating count of out-of-range captures.

## Operation
- Combinational pick: `pick` = source[in_sel] when in_sel < NUM_IN; otherwise `pick` = source 0. `bad` = in_valid & (in_sel >= NUM_IN).
- Per-edge priority for the data path (`out_data`, `out_valid`, `out_sel`) is flush > stall > capture:
  - flush: `out_valid`<=0, `out_data`<=RESET_VAL, `out_sel`<=0.
  - stall (flush=0): all three registers hold.
  - capture with in_valid=1: `out_data`<=pick, `out_sel`<=applied index, `out_valid`<=1.
  - capture with in_valid=0: `out_valid`<=0, and `out_data`/`out_sel` hold their last values. A bubble does not disturb operand data.
- Error path:
  - It updates only on a capture edge, i.e. when flush=0 and stall=0.
  - A capture with `bad`=1 sets `sel_err`<=1 and increments `err_cnt`, which saturates at 255.
  - `err_clr` has priority over every other event: `sel_err`<=0 and `err_cnt`<=0, even when `bad` is set on the same edge.
  - `err_clr` is honoured regardless of stall or flush.
- When NUM_IN = 2**SEL_W, no select is out of range and `sel_err` stays 0.

## Timing
- Latency: 1 cycle from input to `out_data`/`out_valid`. There is no combinational path from any input to any output.
- Reset (`rst_n`=0, asynchronous, immediate) drives the outputs to: `out_data`=RESET_VAL, `out_valid`=0, `out_sel`=0, `sel_err`=0, `err_cnt`=0.
- Reset release is synchronous to `clk` in the surrounding design. The first capture occurs on the first rising edge with `rst_n`=1.
- Reset asserted mid-stall or mid-flush overrides both; state returns to reset values with no edge required.
- Simultaneous stall and flush: flush wins, and the bubble is inserted.
- Stall held for N cycles: the outputs are stable for N cycles, and input changes during the stall are ignored and lost.
- Saturation: when `err_cnt`=255 and another bad capture occurs, `err_cnt` stays 255 and `sel_err` stays 1.

## Test plan
- Reset and basic select, with NUM_IN=3, SEL_W=2, WIDTH=32, and sources 0x11111111, 0x22222222, 0x33333333:
  - Assert `rst_n`=0 → `out_data`=0, `out_valid`=0.
  - Release, then sel=0,1,2 with in_valid=1 on consecutive edges → `out_data` is 0x11111111, 0x22222222, 0x33333333, each one cycle after its select; `out_valid`=1.
- Out-of-range select: sel=3 with in_valid=1 → `out_data`=0x11111111, `out_sel`=0, `sel_err`=1, `err_cnt`=1. The same sel=3 with in_valid=0 → `err_cnt` is unchanged.
- Stall and flush: capture 0x22222222, then stall=1 for 3 cycles while sel changes → `out_data` holds 0x22222222. Assert stall=1 and flush=1 together → next edge gives `out_valid`=0, `out_data`=RESET_VAL.
- Bubble hold: capture 0x33333333, then in_valid=0 on the next edge → `out_valid`=0, `out_data` still 0x33333333.
- Saturation and clear: apply 260 bad captures → `err_cnt`=255. Assert err_clr=1 together with a bad capture → `err_cnt`=0, `sel_err`=0.
- Asynchronous reset mid-operation: during stall with `out_valid`=1, pulse `rst_n` low between clock edges → all outputs reach reset values before the next rising edge.

Source files
------------

// File: rtl/fwd_sel_stage_if.sv
// fwd_sel_stage_if: operand-select bus between the hazard/forwarding unit and the
// ID/EX select stage.
//   in_data   packed sources, source k at [k*WIDTH +: WIDTH]
//   in_sel    binary source index
//   in_valid  input carries a real operand
//   stall     hold the stage
//   flush     insert a bubble
//   err_clr   clear the select-error state
//   out_data  registered operand
//   out_valid registered valid
//   out_sel   select actually applied
//   sel_err   sticky out-of-range flag
//   err_cnt   saturating out-of-range count
// master = driver side (forwarding unit), slave = the stage.
interface fwd_sel_stage_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    stall;
    logic                    flush;
    logic                    err_clr;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;
    logic [7:0]              err_cnt;

    modport master (
        output in_data, in_sel, in_valid, stall, flush, err_clr,
        input  out_data, out_valid, out_sel, sel_err, err_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, stall, flush, err_clr,
        output out_data, out_valid, out_sel, sel_err, err_cnt
    );
endinterface

// File: rtl/fwd_sel_stage.sv
// fwd_sel_stage: N-way operand select with a registered output at the ID/EX boundary.
// Picks one of NUM_IN sources by in_sel, registers it with valid tracking, honours
// stall (hold) and flush (bubble), and flags out-of-range selects with a sticky bit
// and a saturating 8-bit counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fwd_sel_stage_if.slave (inputs in_*, stall, flush, err_clr; outputs out_*,
//          sel_err, err_cnt)
module fwd_sel_stage #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     NUM_IN    = 4,
    parameter int unsigned     SEL_W     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic             clk,
    input logic             rst_n,
    fwd_sel_stage_if.slave  bus
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             sel_err_q, sel_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] pick;
    logic [SEL_W-1:0] sel_app;
    logic             in_range;
    logic             bad;
    logic             capture;

    // Out-of-range selects fall back to source 0 and report index 0.
    always_comb begin
        pick     = bus.in_data[WIDTH-1:0];
        sel_app  = '0;
        in_range = 1'b0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                pick     = bus.in_data[k*WIDTH +: WIDTH];
                sel_app  = SEL_W'(k);
                in_range = 1'b1;
            end
        end
    end

    assign bad     = bus.in_valid & ~in_range;
    assign capture = ~bus.flush & ~bus.stall;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        if (bus.flush) begin
            out_data_d  = RESET_VAL;
            out_valid_d = 1'b0;
            out_sel_d   = '0;
        end else if (!bus.stall) begin
            out_valid_d = bus.in_valid;
            // A bubble leaves the operand data and select untouched.
            if (bus.in_valid) begin
                out_data_d = pick;
                out_sel_d  = sel_app;
            end
        end
    end

    // err_clr beats everything, including a bad capture on the same edge.
    always_comb begin
        sel_err_d = sel_err_q;
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            sel_err_d = 1'b0;
            err_cnt_d = '0;
        end else if (capture && bad) begin
            sel_err_d = 1'b1;
            if (err_cnt_q != 8'hff) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= RESET_VAL;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fwd_sel_stage.sv
// Directed bench for fwd_sel_stage with NUM_IN=3, SEL_W=2, WIDTH=32, RESET_VAL=0.
module tb_fwd_sel_stage;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_IN = 3;
    localparam int unsigned SEL_W  = 2;

    localparam logic [31:0] S0 = 32'h1111_1111;
    localparam logic [31:0] S1 = 32'h2222_2222;
    localparam logic [31:0] S2 = 32'h3333_3333;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    fwd_sel_stage_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    fwd_sel_stage #(
        .WIDTH    (WIDTH),
        .NUM_IN   (NUM_IN),
        .SEL_W    (SEL_W),
        .RESET_VAL(32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic vld, input logic stl,
                         input logic fls, input logic clr);
        bus.in_sel   = sel;
        bus.in_valid = vld;
        bus.stall    = stl;
        bus.flush    = fls;
        bus.err_clr  = clr;
    endtask

    task automatic check_out(input string tag, input logic [31:0] d, input logic v,
                             input logic [1:0] s);
        check({tag, ".data"}, bus.out_data, d);
        check({tag, ".valid"}, {31'b0, bus.out_valid}, {31'b0, v});
        check({tag, ".sel"}, {30'b0, bus.out_sel}, {30'b0, s});
    endtask

    task automatic check_err(input string tag, input logic e, input logic [7:0] c);
        check({tag, ".sel_err"}, {31'b0, bus.sel_err}, {31'b0, e});
        check({tag, ".err_cnt"}, {24'b0, bus.err_cnt}, {24'b0, c});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_data = {S2, S1, S0};
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_out("reset", 32'h0, 1'b0, 2'd0);
        check_err("reset", 1'b0, 8'd0);
        rst_n = 1'b1;

        // Basic select on consecutive edges
        drive(2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("sel0", S0, 1'b1, 2'd0);
        drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("sel1", S1, 1'b1, 2'd1);
        drive(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("sel2", S2, 1'b1, 2'd2);
        check_err("sel2", 1'b0, 8'd0);

        // Out-of-range select substitutes source 0
        drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("oor", S0, 1'b1, 2'd0);
        check_err("oor", 1'b1, 8'd1);
        drive(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("oor_inv", S0, 1'b0, 2'd0);
        check_err("oor_inv", 1'b1, 8'd1);

        // Stall holds; bad selects during stall are not counted
        drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("pre_stall", S1, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            drive(2'(i + 1), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            check_out($sformatf("stall%0d", i), S1, 1'b1, 2'd1);
        end
        check_err("stall", 1'b1, 8'd1);

        // Stall and flush together: flush wins
        drive(2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_out("stall_flush", 32'h0, 1'b0, 2'd0);

        // Bubble keeps operand data
        drive(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("cap2", S2, 1'b1, 2'd2);
        drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("bubble", S2, 1'b0, 2'd2);

        // Flush blocks error counting
        drive(2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check_out("flush_bad", 32'h0, 1'b0, 2'd0);
        check_err("flush_bad", 1'b1, 8'd1);

        // Saturation: 1 + 260 bad captures clamps at 255
        drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) tick();
        check_out("sat", S0, 1'b1, 2'd0);
        check_err("sat", 1'b1, 8'd255);

        // Clear beats a simultaneous bad capture
        drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check_err("clr_bad", 1'b0, 8'd0);

        // Clear honoured while stalled
        drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_err("bad_again", 1'b1, 8'd1);
        drive(2'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check_err("clr_stall", 1'b0, 8'd0);

        // Asynchronous reset mid-stall
        drive(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("pre_rst", S1, 1'b1, 2'd1);
        drive(2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_err("pre_rst", 1'b1, 8'd1);
        drive(2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 32'h0, 1'b0, 2'd0);
        check_err("async_rst", 1'b0, 8'd0);
        #1 rst_n = 1'b1;
        drive(2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("post_rst", S2, 1'b1, 2'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
